// File: rtl/param_ram.sv
// Single-port byte-writable RAM with power-on clear controller.
// Ports: clk, rst, en, we, be, addr, wdata in; ready, rdata, rvalid out.
module param_ram #(
  parameter int  DATA_W   = 16,
  parameter int  ADDR_W   = 6,
  parameter int  RDW_MODE = 0,
  parameter int  OUT_REG  = 0,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   res_word;

  // ready mirrors state, so gating on it drops requests during clear
  assign acc      = en && ready;
  assign old_word = mem[addr];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // reads and RDW_MODE=0 writes report the word before this edge
  assign res_word = (RDW_MODE != 0 && we) ? merged : old_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

  // no reset on the array; the clear sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (acc && we) begin
        mem[addr] <= merged;
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid <= 1'b0;
          rdata  <= '0;
        end else begin
          rvalid <= acc;
          if (acc) begin
            rdata <= res_word;
          end
        end
      end
    end else begin : g_lat2
      logic              p_valid;
      logic [DATA_W-1:0] p_data;

      // reset clears p_valid so in-flight results never surface
      always_ff @(posedge clk) begin
        if (rst) begin
          p_valid <= 1'b0;
          p_data  <= '0;
          rvalid  <= 1'b0;
          rdata   <= '0;
        end else begin
          p_valid <= acc;
          if (acc) begin
            p_data <= res_word;
          end
          rvalid <= p_valid;
          if (p_valid) begin
            rdata <= p_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram: two instances side by side,
// (RDW_MODE=0, OUT_REG=0) and (RDW_MODE=1, OUT_REG=1).
module tb_param_ram;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [5:0]  addr = '0;
  logic [15:0] wdata = '0;

  logic        ready0, rvalid0;
  logic [15:0] rdata0;
  logic        ready1, rvalid1;
  logic [15:0] rdata1;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        rst_edge = 1'b1;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] model [64];
  logic [15:0] prev0 = '0;
  logic [15:0] prev1 = '0;

  param_ram #(.RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be),
    .addr(addr), .wdata(wdata),
    .ready(ready0), .rdata(rdata0), .rvalid(rvalid0)
  );

  param_ram #(.RDW_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be),
    .addr(addr), .wdata(wdata),
    .ready(ready1), .rdata(rdata1), .rvalid(rvalid1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rdata0", rdata0, 0);
    end else if (rvalid0) begin
      if (q0.size() == 0) begin
        chk("spurious_rvalid0", rvalid0, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("rdata0", rdata0, e.d);
        chk("lat0", cyc, e.due);
      end
    end else begin
      chk("hold0", rdata0, prev0);
      if (q0.size() != 0 && q0[0].due <= cyc) begin
        exp_t e;
        e = q0.pop_front();
        chk("missing_rvalid0", rvalid0, 1);
      end
    end
    prev0 = rdata0;
  end

  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_rdata1", rdata1, 0);
    end else if (rvalid1) begin
      if (q1.size() == 0) begin
        chk("spurious_rvalid1", rvalid1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("rdata1", rdata1, e.d);
        chk("lat1", cyc, e.due);
      end
    end else begin
      chk("hold1", rdata1, prev1);
      if (q1.size() != 0 && q1[0].due <= cyc) begin
        exp_t e;
        e = q1.pop_front();
        chk("missing_rvalid1", rvalid1, 1);
      end
    end
    prev1 = rdata1;
  end

  // one accepted access; expectations pushed as it is driven
  task automatic op(bit w, logic [5:0] a, logic [15:0] d,
                    logic [1:0] b, bit push1);
    logic [15:0] old, mrg;
    old = model[a];
    mrg = old;
    if (b[0]) mrg[7:0]  = d[7:0];
    if (b[1]) mrg[15:8] = d[15:8];
    en = 1'b1; we = w; addr = a; wdata = d; be = b;
    q0.push_back('{old, cyc + 1});
    if (push1) q1.push_back('{(w ? mrg : old), cyc + 2});
    if (w) model[a] = mrg;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic wr(logic [5:0] a, logic [15:0] d, logic [1:0] b);
    op(1'b1, a, d, b, 1'b1);
  endtask

  task automatic rd(logic [5:0] a);
    op(1'b0, a, 16'h0, 2'b00, 1'b1);
  endtask

  // counts ready-low cycles from rst release, optionally
  // hammering a write to addr 3 while busy
  task automatic wait_clear(string tag, bit busy);
    int zc;
    zc = 0;
    for (int i = 0; i < 80; i++) begin
      if (ready0) break;
      zc++;
      if (busy && i >= 5 && i < 20) begin
        en = 1'b1; we = 1'b1; addr = 6'd3;
        wdata = 16'hFFFF; be = 2'b11;
      end else begin
        en = 1'b0; we = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0; we = 1'b0;
    chk(tag, zc, 64);
    chk({tag, "_ready1"}, ready1, 1);
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", ready0, 0);
    chk("rst_ready1", ready1, 0);
    rst = 1'b0;
    wait_clear("clear_len", 1'b1);

    for (int a = 0; a < 64; a++) rd(6'(a));
    rd(6'd3);

    wr(6'd5, 16'hABCD, 2'b11);
    wr(6'd5, 16'h1234, 2'b01);
    rd(6'd5);

    wr(6'd9, 16'h5555, 2'b11);
    wr(6'd9, 16'hAAAA, 2'b11);
    rd(6'd9);

    wr(6'd7, 16'h1357, 2'b11);
    rd(6'd7);
    wr(6'd7, 16'hFFFF, 2'b00);
    rd(6'd7);

    for (int a = 0; a < 64; a++) wr(6'(a), 16'(a), 2'b11);
    for (int a = 0; a < 64; a++) rd(6'(a));

    for (int i = 0; i < 120; i++) begin
      op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
         16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
    end
    repeat (4) @(negedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_clear_ready", ready0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("reclear_len", 1'b0);
    for (int a = 0; a < 8; a++) rd(6'(a * 9));

    wr(6'd10, 16'hBEEF, 2'b11);
    repeat (3) @(negedge clk);
    op(1'b0, 6'd10, 16'h0, 2'b00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("inflight_rvalid1", rvalid1, 0);
    rst = 1'b0;
    wait_clear("post_inflight_len", 1'b0);
    rd(6'd10);
    rd(6'd63);
    repeat (4) @(negedge clk);
    chk("final_q0", q0.size(), 0);
    chk("final_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
